player_input_ctrl: RTL and testbench

Parametrised direction-input front end for N players in the Pacman design. It merges debounced board switches and PS2 scan-code make/break tracking into per-player held and latched directions. The processor reads these as its movement inputs, replacing the raw per-switch up/right/down/left signals. It sits between the switch pins / PS2_Interface and proc_skeleton.

---
 rtl/player_input_ctrl.sv | 170 +++++++++++++++++
 tb/tb_player_input_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/player_input_ctrl.sv
// Direction-input front end: debounced switches plus PS/2 make/break tracking,
// merged into per-player held directions and a latched last-pressed direction.
module player_input_ctrl #(
  parameter int NUM_PLAYERS     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int SRC_MODE        = 2,
  parameter logic [NUM_PLAYERS*36-1:0] KEYMAP = {
    9'h16B, 9'h172, 9'h174, 9'h175,  // player 1: left, down, right, up (E0 prefix)
    9'h01C, 9'h01B, 9'h023, 9'h01D   // player 0: A, S, D, W
  }
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [4*NUM_PLAYERS-1:0] sw,
  input  logic                     ps2_key_pressed,
  input  logic [7:0]               ps2_key_data,
  output logic [4*NUM_PLAYERS-1:0] dir_held,
  output logic [2*NUM_PLAYERS-1:0] dir_code,
  output logic [NUM_PLAYERS-1:0]   dir_valid,
  output logic [NUM_PLAYERS-1:0]   dir_change
);

  localparam int NB = 4 * NUM_PLAYERS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} kb_state_t;

  logic [NB-1:0] stable_bits;
  logic [NB-1:0] key_held_reg;
  logic [NB-1:0] merged;
  logic [NB-1:0] dir_held_reg;
  logic [NB-1:0] dir_held_prev_reg;
  kb_state_t     kb_state_reg;
  logic          kb_make;
  logic          kb_break;
  logic          kb_ext;

  // Per-switch synchroniser and debouncer; stable flips only after a full run
  // of DEBOUNCE_CYCLES cycles disagreeing with it.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_sw
      logic             s1_reg;
      logic             s2_reg;
      logic             stable_reg;
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clock) begin
        if (!resetn) begin
          s1_reg     <= 1'b0;
          s2_reg     <= 1'b0;
          stable_reg <= 1'b0;
          cnt_reg    <= '0;
        end else begin
          s1_reg <= sw[gi];
          s2_reg <= s1_reg;
          if (s2_reg == stable_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            stable_reg <= ~stable_reg;
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign stable_bits[gi] = stable_reg;
    end
  endgenerate

  always_comb begin
    kb_make  = 1'b0;
    kb_break = 1'b0;
    kb_ext   = 1'b0;
    if (ps2_key_pressed) begin
      case (kb_state_reg)
        IDLE:    kb_make = (ps2_key_data != 8'hE0) && (ps2_key_data != 8'hF0) &&
                           (ps2_key_data != 8'hE1);
        EXT: begin
          kb_ext  = 1'b1;
          kb_make = (ps2_key_data != 8'hF0);
        end
        BRK:     kb_break = 1'b1;
        EXT_BRK: begin
          kb_ext   = 1'b1;
          kb_break = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Scan-code sequencer; every KEYMAP entry is matched so duplicates all follow.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      kb_state_reg <= IDLE;
      key_held_reg <= '0;
    end else if (ps2_key_pressed) begin
      case (kb_state_reg)
        IDLE: begin
          if (ps2_key_data == 8'hE0)      kb_state_reg <= EXT;
          else if (ps2_key_data == 8'hF0) kb_state_reg <= BRK;
          else                            kb_state_reg <= IDLE;
        end
        EXT:     kb_state_reg <= (ps2_key_data == 8'hF0) ? EXT_BRK : IDLE;
        default: kb_state_reg <= IDLE;
      endcase
      for (int i = 0; i < NB; i++) begin
        if ({kb_ext, ps2_key_data} == KEYMAP[9*i +: 9]) begin
          if (kb_make)       key_held_reg[i] <= 1'b1;
          else if (kb_break) key_held_reg[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    merged = stable_bits | key_held_reg;
    if (SRC_MODE == 0)      merged = stable_bits;
    else if (SRC_MODE == 1) merged = key_held_reg;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      dir_held_reg      <= '0;
      dir_held_prev_reg <= '0;
    end else begin
      dir_held_reg      <= merged;
      dir_held_prev_reg <= dir_held_reg;
    end
  end

  assign dir_held = dir_held_reg;

  // Latch the newest press; release leaves the direction untouched.
  generate
    for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_latch
      logic [3:0] rise;
      logic [1:0] code_reg;
      logic       valid_reg;
      logic       change_reg;

      assign rise = dir_held_reg[4*gi +: 4] & ~dir_held_prev_reg[4*gi +: 4];

      always_ff @(posedge clock) begin
        if (!resetn) begin
          code_reg   <= 2'd0;
          valid_reg  <= 1'b0;
          change_reg <= 1'b0;
        end else begin
          change_reg <= |rise;
          if (|rise) begin
            valid_reg <= 1'b1;
            if (rise[0])      code_reg <= 2'd0;
            else if (rise[1]) code_reg <= 2'd1;
            else if (rise[2]) code_reg <= 2'd2;
            else              code_reg <= 2'd3;
          end
        end
      end

      assign dir_code[2*gi +: 2] = code_reg;
      assign dir_valid[gi]       = valid_reg;
      assign dir_change[gi]      = change_reg;
    end
  endgenerate

endmodule

// File: tb/tb_player_input_ctrl.sv
// Directed bench for player_input_ctrl with a short debounce window; three
// instances differ only in SRC_MODE so the source selection can be compared.
module tb_player_input_ctrl;

  logic       clock;
  logic       resetn;
  logic [7:0] sw;
  logic       ps2_key_pressed;
  logic [7:0] ps2_key_data;

  logic [7:0] dir_held, held_sw, held_kb;
  logic [3:0] dir_code, code_sw, code_kb;
  logic [1:0] dir_valid, valid_sw, valid_kb;
  logic [1:0] dir_change, change_sw, change_kb;

  int n_cmp = 0;
  int n_err = 0;

  player_input_ctrl #(.NUM_PLAYERS(2), .DEBOUNCE_CYCLES(4), .CNT_W(3), .SRC_MODE(2)) dut (
    .clock(clock), .resetn(resetn), .sw(sw), .ps2_key_pressed(ps2_key_pressed),
    .ps2_key_data(ps2_key_data), .dir_held(dir_held), .dir_code(dir_code),
    .dir_valid(dir_valid), .dir_change(dir_change));

  player_input_ctrl #(.NUM_PLAYERS(2), .DEBOUNCE_CYCLES(4), .CNT_W(3), .SRC_MODE(0)) dut_sw (
    .clock(clock), .resetn(resetn), .sw(sw), .ps2_key_pressed(ps2_key_pressed),
    .ps2_key_data(ps2_key_data), .dir_held(held_sw), .dir_code(code_sw),
    .dir_valid(valid_sw), .dir_change(change_sw));

  player_input_ctrl #(.NUM_PLAYERS(2), .DEBOUNCE_CYCLES(4), .CNT_W(3), .SRC_MODE(1)) dut_kb (
    .clock(clock), .resetn(resetn), .sw(sw), .ps2_key_pressed(ps2_key_pressed),
    .ps2_key_data(ps2_key_data), .dir_held(held_kb), .dir_code(code_kb),
    .dir_valid(valid_kb), .dir_change(change_kb));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    $display("tx ps2 byte %h", b);
    ps2_key_data    = b;
    ps2_key_pressed = 1'b1;
    step(1);
    ps2_key_pressed = 1'b0;
    ps2_key_data    = 8'h00;
  endtask

  task automatic set_sw(input logic [7:0] v);
    $display("tx sw %b", v);
    sw = v;
  endtask

  task automatic test_reset;
    set_sw(8'hFF);
    resetn = 1'b0;
    step(1);
    n_cmp++; if (dir_held !== 8'h00) begin n_err++; $display("FAIL reset_held: got %h expected 00", dir_held); end
    n_cmp++; if (dir_code !== 4'h0) begin n_err++; $display("FAIL reset_code: got %h expected 0", dir_code); end
    n_cmp++; if (dir_valid !== 2'b00) begin n_err++; $display("FAIL reset_valid: got %b expected 00", dir_valid); end
    n_cmp++; if (dir_change !== 2'b00) begin n_err++; $display("FAIL reset_change: got %b expected 00", dir_change); end
    set_sw(8'h00);
    step(2);
    resetn = 1'b1;
    step(10);
    n_cmp++; if (dir_held !== 8'h00) begin n_err++; $display("FAIL post_reset_held: got %h expected 00", dir_held); end
  endtask

  task automatic test_debounce;
    set_sw(8'h02);
    step(6);
    n_cmp++; if (dir_held !== 8'h00) begin n_err++; $display("FAIL debounce_early: got %h expected 00", dir_held); end
    step(1);
    n_cmp++; if (dir_held !== 8'h02) begin n_err++; $display("FAIL debounce_held: got %h expected 02", dir_held); end
    n_cmp++; if (dir_change !== 2'b00) begin n_err++; $display("FAIL debounce_change_early: got %b expected 00", dir_change); end
    step(1);
    n_cmp++; if (dir_code !== 4'h1) begin n_err++; $display("FAIL debounce_code: got %h expected 1", dir_code); end
    n_cmp++; if (dir_valid !== 2'b01) begin n_err++; $display("FAIL debounce_valid: got %b expected 01", dir_valid); end
    n_cmp++; if (dir_change !== 2'b01) begin n_err++; $display("FAIL debounce_change: got %b expected 01", dir_change); end
    step(1);
    n_cmp++; if (dir_change !== 2'b00) begin n_err++; $display("FAIL debounce_pulse_width: got %b expected 00", dir_change); end
  endtask

  task automatic test_glitch;
    set_sw(8'h03);
    step(3);
    set_sw(8'h02);
    step(10);
    n_cmp++; if (dir_held !== 8'h02) begin n_err++; $display("FAIL glitch_held: got %h expected 02", dir_held); end
    n_cmp++; if (dir_code !== 4'h1) begin n_err++; $display("FAIL glitch_code: got %h expected 1", dir_code); end
  endtask

  task automatic test_release;
    set_sw(8'h00);
    step(10);
    n_cmp++; if (dir_held !== 8'h00) begin n_err++; $display("FAIL release_held: got %h expected 00", dir_held); end
    n_cmp++; if (dir_code !== 4'h1) begin n_err++; $display("FAIL release_code: got %h expected 1", dir_code); end
    n_cmp++; if (dir_valid !== 2'b01) begin n_err++; $display("FAIL release_valid: got %b expected 01", dir_valid); end
  endtask

  task automatic test_kbd_ext;
    send(8'hE0); send(8'h75);
    step(1);
    n_cmp++; if (dir_held !== 8'h10) begin n_err++; $display("FAIL ext_make_held: got %h expected 10", dir_held); end
    step(1);
    n_cmp++; if (dir_code !== 4'h1) begin n_err++; $display("FAIL ext_make_code: got %h expected 1", dir_code); end
    n_cmp++; if (dir_valid !== 2'b11) begin n_err++; $display("FAIL ext_make_valid: got %b expected 11", dir_valid); end
    n_cmp++; if (dir_change !== 2'b10) begin n_err++; $display("FAIL ext_make_change: got %b expected 10", dir_change); end
    send(8'hE0); send(8'h74);
    step(2);
    n_cmp++; if (dir_code !== 4'h5) begin n_err++; $display("FAIL ext_second_code: got %h expected 5", dir_code); end
    send(8'hE0); send(8'hF0); send(8'h75);
    step(1);
    n_cmp++; if (dir_held !== 8'h20) begin n_err++; $display("FAIL ext_break_held: got %h expected 20", dir_held); end
    step(3);
    n_cmp++; if (dir_code !== 4'h5) begin n_err++; $display("FAIL ext_break_code: got %h expected 5", dir_code); end
    n_cmp++; if (dir_change !== 2'b00) begin n_err++; $display("FAIL ext_break_change: got %b expected 00", dir_change); end
    send(8'hE0); send(8'hF0); send(8'h74);
    step(2);
    n_cmp++; if (dir_held !== 8'h00) begin n_err++; $display("FAIL ext_break2_held: got %h expected 00", dir_held); end
  endtask

  task automatic test_kbd_unmapped;
    send(8'hE0); send(8'h12);
    step(3);
    n_cmp++; if (dir_held !== 8'h00) begin n_err++; $display("FAIL unmapped_held: got %h expected 00", dir_held); end
    n_cmp++; if (dir_code !== 4'h5) begin n_err++; $display("FAIL unmapped_code: got %h expected 5", dir_code); end
    send(8'hE1);
    step(3);
    n_cmp++; if (dir_held !== 8'h00) begin n_err++; $display("FAIL e1_held: got %h expected 00", dir_held); end
  endtask

  task automatic test_back_to_back;
    send(8'h1D); send(8'h1C);
    n_cmp++; if (dir_held !== 8'h01) begin n_err++; $display("FAIL b2b_held_up: got %h expected 01", dir_held); end
    step(1);
    n_cmp++; if (dir_code !== 4'h4) begin n_err++; $display("FAIL b2b_code_up: got %h expected 4", dir_code); end
    n_cmp++; if (dir_change !== 2'b01) begin n_err++; $display("FAIL b2b_change_up: got %b expected 01", dir_change); end
    step(1);
    n_cmp++; if (dir_code !== 4'h7) begin n_err++; $display("FAIL b2b_code_left: got %h expected 7", dir_code); end
    n_cmp++; if (dir_change !== 2'b01) begin n_err++; $display("FAIL b2b_change_left: got %b expected 01", dir_change); end
    send(8'hF0); send(8'h1D); send(8'hF0); send(8'h1C);
    step(2);
    n_cmp++; if (dir_held !== 8'h00) begin n_err++; $display("FAIL b2b_released: got %h expected 00", dir_held); end
    n_cmp++; if (dir_code !== 4'h7) begin n_err++; $display("FAIL b2b_code_kept: got %h expected 7", dir_code); end
    set_sw(8'h0A);
    step(7);
    n_cmp++; if (dir_held !== 8'h0A) begin n_err++; $display("FAIL simul_held: got %h expected 0a", dir_held); end
    step(1);
    n_cmp++; if (dir_code !== 4'h5) begin n_err++; $display("FAIL simul_priority: got %h expected 5", dir_code); end
    n_cmp++; if (dir_change !== 2'b01) begin n_err++; $display("FAIL simul_change: got %b expected 01", dir_change); end
    set_sw(8'h00);
    step(10);
  endtask

  task automatic test_mode;
    set_sw(8'h04);
    send(8'h1C);
    step(9);
    n_cmp++; if (held_sw !== 8'h04) begin n_err++; $display("FAIL mode0_held: got %h expected 04", held_sw); end
    n_cmp++; if (held_kb !== 8'h08) begin n_err++; $display("FAIL mode1_held: got %h expected 08", held_kb); end
    n_cmp++; if (dir_held !== 8'h0C) begin n_err++; $display("FAIL mode2_held: got %h expected 0c", dir_held); end
    set_sw(8'h00);
    send(8'hF0); send(8'h1C);
    step(10);
    n_cmp++; if (dir_held !== 8'h00) begin n_err++; $display("FAIL mode_cleanup: got %h expected 00", dir_held); end
  endtask

  task automatic test_reset_mid;
    send(8'hE0); send(8'hF0);
    resetn = 1'b0;
    step(1);
    resetn = 1'b1;
    send(8'h75);
    step(3);
    n_cmp++; if (dir_held !== 8'h00) begin n_err++; $display("FAIL midrst_brk_held: got %h expected 00", dir_held); end
    n_cmp++; if (dir_valid !== 2'b00) begin n_err++; $display("FAIL midrst_brk_valid: got %b expected 00", dir_valid); end
    n_cmp++; if (dir_code !== 4'h0) begin n_err++; $display("FAIL midrst_brk_code: got %h expected 0", dir_code); end
    send(8'hE0);
    resetn = 1'b0;
    step(1);
    resetn = 1'b1;
    send(8'h75);
    step(3);
    n_cmp++; if (dir_held !== 8'h00) begin n_err++; $display("FAIL midrst_ext_held: got %h expected 00", dir_held); end
    n_cmp++; if (dir_valid !== 2'b00) begin n_err++; $display("FAIL midrst_ext_valid: got %b expected 00", dir_valid); end
  endtask

  initial begin
    resetn          = 1'b0;
    sw              = 8'h00;
    ps2_key_pressed = 1'b0;
    ps2_key_data    = 8'h00;
    test_reset();
    test_debounce();
    test_glitch();
    test_release();
    test_kbd_ext();
    test_kbd_unmapped();
    test_back_to_back();
    test_mode();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
